// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences the shared datapath
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic        reg_write,
  output logic [3:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     cur_state;
  state_t     next_state;
  logic       alu_funct_ok;
  logic [2:0] alu_funct_op;

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      instret   <= 32'd0;
      illegal   <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (next_state == S_FETCH &&
          (cur_state == S_MEMWB || cur_state == S_MEMWRITE ||
           cur_state == S_ALUWB || cur_state == S_BRANCH))
        instret <= instret + 32'd1;
      if (next_state == S_TRAP)
        illegal <= 1'b1;
    end
  end

  // ALU operation for R/I-type arithmetic; subtract only for R-type with instr[30] set
  always_comb begin
    alu_funct_ok = 1'b1;
    alu_funct_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct_op = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct_op = ALU_SLT;
      3'b110:  alu_funct_op = ALU_OR;
      3'b111:  alu_funct_op = ALU_AND;
      default: alu_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:     imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  always_comb begin
    next_state  = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;

    case (cur_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_RTYPE:     next_state = alu_funct_ok ? S_EXECUTER : S_TRAP;
          OP_ITYPE:     next_state = alu_funct_ok ? S_EXECUTEI : S_TRAP;
          OP_JAL:       next_state = S_JAL;
          OP_BRANCH:    next_state = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = alu_funct_op;
        next_state  = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_funct_op;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = (funct3 == 3'b000) ? zero : ~zero;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset suppresses every architectural write, whatever state we are in
    if (rst) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm: walks each instruction class
// through its state sequence and checks enables, selects and counters.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic [1:0]  imm_src;
  logic        reg_write;
  logic [3:0]  state;
  logic [31:0] instret;
  logic        illegal;

  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_instret;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
    .state(state), .instret(instret), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (state !== 4'd0 || instret !== 32'd0 || illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got state=%0d instret=%0d illegal=%0b, want 0/0/0", state, instret, illegal);
    end
    tests_run++;
    if (pc_write !== 1'b0 || ir_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_enables: got pc_write=%0b ir_write=%0b, want 0/0", pc_write, ir_write);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (pc_write !== 1'b1 || ir_write !== 1'b1 || adr_src !== 1'b0 ||
        alu_src_b !== 2'b10 || result_src !== 2'b10 || alu_control !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL fetch_after_reset: got pc_write=%0b ir_write=%0b adr_src=%0b src_b=%0b result_src=%0b alu=%0b",
               pc_write, ir_write, adr_src, alu_src_b, result_src, alu_control);
    end
  endtask

  task automatic test_lw;
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (state !== seq[i] || reg_write !== (seq[i] == 4'd4)) begin
        tests_failed++;
        $display("[TB] FAIL lw_cycle%0d: got state=%0d reg_write=%0b, want state=%0d reg_write=%0b",
                 i, state, reg_write, seq[i], seq[i] == 4'd4);
      end
      if (seq[i] == 4'd4) begin
        tests_run++;
        if (result_src !== 2'b01) begin
          tests_failed++;
          $display("[TB] FAIL lw_result_src: got %0b want 01", result_src);
        end
      end
      if (seq[i] == 4'd3) begin
        tests_run++;
        if (adr_src !== 1'b1 || mem_write !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL lw_memread: got adr_src=%0b mem_write=%0b want 1/0", adr_src, mem_write);
        end
      end
      @(negedge clk); #1;
    end
    exp_instret++;
    tests_run++;
    if (state !== 4'd0 || instret !== exp_instret) begin
      tests_failed++;
      $display("[TB] FAIL lw_retire: got state=%0d instret=%0d want 0/%0d", state, instret, exp_instret);
    end
  endtask

  task automatic test_sw;
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (imm_src !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL sw_imm_src: got %0b want 01", imm_src);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (state !== seq[i] || mem_write !== (seq[i] == 4'd5) || reg_write !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL sw_cycle%0d: got state=%0d mem_write=%0b reg_write=%0b, want state=%0d mem_write=%0b",
                 i, state, mem_write, reg_write, seq[i], seq[i] == 4'd5);
      end
      @(negedge clk); #1;
    end
    exp_instret++;
    tests_run++;
    if (state !== 4'd0 || instret !== exp_instret) begin
      tests_failed++;
      $display("[TB] FAIL sw_retire: got state=%0d instret=%0d want 0/%0d", state, instret, exp_instret);
    end
  endtask

  task automatic test_alu_ops;
    // op, funct3, funct7b5, execute state, expected alu_control, expected alu_src_b
    logic [6:0] ops  [4] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011};
    logic [2:0] f3s  [4] = '{3'b000, 3'b000, 3'b010, 3'b110};
    logic       f7s  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] exst [4] = '{4'd6, 4'd8, 4'd6, 4'd8};
    logic [2:0] alu  [4] = '{3'b001, 3'b000, 3'b101, 3'b011};
    logic [1:0] srcb [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    for (int t = 0; t < 4; t++) begin
      set_instr(ops[t], f3s[t], f7s[t], 1'b0);
      #1;
      for (int i = 0; i < 4; i++) begin
        logic [3:0] want;
        want = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : (i == 2) ? exst[t] : 4'd7;
        tests_run++;
        if (state !== want || reg_write !== (i == 3)) begin
          tests_failed++;
          $display("[TB] FAIL alu%0d_cycle%0d: got state=%0d reg_write=%0b, want state=%0d reg_write=%0b",
                   t, i, state, reg_write, want, i == 3);
        end
        if (i == 2) begin
          tests_run++;
          if (alu_control !== alu[t] || alu_src_a !== 2'b10 || alu_src_b !== srcb[t]) begin
            tests_failed++;
            $display("[TB] FAIL alu%0d_execute: got alu=%0b src_a=%0b src_b=%0b, want alu=%0b src_a=10 src_b=%0b",
                     t, alu_control, alu_src_a, alu_src_b, alu[t], srcb[t]);
          end
        end
        @(negedge clk); #1;
      end
      exp_instret++;
      tests_run++;
      if (state !== 4'd0 || instret !== exp_instret) begin
        tests_failed++;
        $display("[TB] FAIL alu%0d_retire: got state=%0d instret=%0d want 0/%0d", t, state, instret, exp_instret);
      end
    end
  endtask

  task automatic test_branch;
    // funct3, zero, expected pc_write in BRANCH
    logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       pcw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      set_instr(7'b1100011, f3s[t], 1'b0, zs[t]);
      #1;
      tests_run++;
      if (imm_src !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL br%0d_imm_src: got %0b want 10", t, imm_src);
      end
      repeat (2) begin @(negedge clk); end
      #1;
      tests_run++;
      if (state !== 4'd10 || pc_write !== pcw[t] || alu_control !== 3'b001) begin
        tests_failed++;
        $display("[TB] FAIL br%0d_branch: got state=%0d pc_write=%0b alu=%0b, want 10/%0b/001",
                 t, state, pc_write, alu_control, pcw[t]);
      end
      @(negedge clk); #1;
      exp_instret++;
      tests_run++;
      if (state !== 4'd0 || instret !== exp_instret) begin
        tests_failed++;
        $display("[TB] FAIL br%0d_retire: got state=%0d instret=%0d want 0/%0d", t, state, instret, exp_instret);
      end
    end
  endtask

  task automatic test_jal;
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd9, 4'd7};
    logic       pcw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       rgw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (state !== seq[i] || pc_write !== pcw[i] || reg_write !== rgw[i] || imm_src !== 2'b11) begin
        tests_failed++;
        $display("[TB] FAIL jal_cycle%0d: got state=%0d pc_write=%0b reg_write=%0b imm_src=%0b, want %0d/%0b/%0b/11",
                 i, state, pc_write, reg_write, imm_src, seq[i], pcw[i], rgw[i]);
      end
      @(negedge clk); #1;
    end
    exp_instret++;
    tests_run++;
    if (state !== 4'd0 || instret !== exp_instret) begin
      tests_failed++;
      $display("[TB] FAIL jal_retire: got state=%0d instret=%0d want 0/%0d", state, instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid_memwrite;
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    repeat (3) begin @(negedge clk); end
    #1;
    tests_run++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_reach: got state=%0d mem_write=%0b want 5/1", state, mem_write);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_mem_write: got %0b want 0", mem_write);
    end
    @(negedge clk); #1;
    tests_run++;
    if (state !== 4'd0 || instret !== 32'd0 || illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_after: got state=%0d instret=%0d illegal=%0b want 0/0/0", state, instret, illegal);
    end
    rst = 1'b0;
    exp_instret = 32'd0;
    #1;
  endtask

  task automatic test_illegal;
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    @(negedge clk); #1;
    tests_run++;
    if (state !== 4'd1 || illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL trap_decode: got state=%0d illegal=%0b want 1/0", state, illegal);
    end
    @(negedge clk); #1;
    tests_run++;
    if (state !== 4'd11 || illegal !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL trap_entry: got state=%0d illegal=%0b want 11/1", state, illegal);
    end
    for (int i = 0; i < 20; i++) begin
      zero = i[0];
      #1;
      tests_run++;
      if (state !== 4'd11 || illegal !== 1'b1 || pc_write !== 1'b0 || mem_write !== 1'b0 ||
          ir_write !== 1'b0 || reg_write !== 1'b0 || instret !== exp_instret) begin
        tests_failed++;
        $display("[TB] FAIL trap_hold%0d: got state=%0d illegal=%0b pcw=%0b memw=%0b irw=%0b regw=%0b instret=%0d",
                 i, state, illegal, pc_write, mem_write, ir_write, reg_write, instret);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (state !== 4'd0 || illegal !== 1'b0 || instret !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL trap_clear: got state=%0d illegal=%0b instret=%0d want 0/0/0", state, illegal, instret);
    end
    rst = 1'b0;
    exp_instret = 32'd0;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_instret  = 32'd0;
    rst = 1'b1;
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    test_reset;
    test_lw;
    test_sw;
    test_alu_ops;
    test_branch;
    test_jal;
    test_reset_mid_memwrite;
    test_lw;
    test_illegal;
    test_jal;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
